sm_data_memory_ctrl: RTL and testbench

// - Parametrised data memory for the SchoolARM datapath. Supports byte, halfword and word

---
 rtl/sm_data_memory_ctrl.sv | 251 +++++++++++++++++++++++++
 tb/tb_sm_data_memory_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sm_data_memory_ctrl.sv
// Data memory controller: byte/half/word loads and stores into an on-chip RAM.
// Latency: response pulse WAIT_STATES+1 cycles after the accept edge; one request in flight.
// Backpressure: req_ready is high only in IDLE; requests are held off through WAIT and RESP.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   req_valid/req_ready   request handshake; fields captured at the accept edge
//   req_write, req_size   1=store/0=load; 00 byte, 01 half, 10 word, 11 reserved (error)
//   req_signed            sign-extend loads
//   adress                byte address; word index = adress[31:2], lane = adress[1:0]
//   write_data            right-aligned store data
//   rsp_valid             one-cycle response pulse
//   read_data, rsp_error  registered load result / rejection flag, valid with rsp_valid
// Build option: define SM_DMEM_MISALIGN_FAULT_EN to reject misaligned half/word accesses
// instead of silently aligning them down.

module sm_data_memory_ctrl #(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 64,
    parameter int WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [31:0]       adress,
    input  logic [DATA_W-1:0] write_data,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] read_data,
    output logic              rsp_error
);

    localparam int          NB         = DATA_W / 8;
    localparam int          IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] DEPTH_W32  = 32'(DEPTH);
    localparam logic [3:0]  WAIT_LOAD  = 4'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         wait_cnt_q, wait_cnt_d;
    logic [DATA_W-1:0]  read_data_q, read_data_d;
    logic               rsp_error_q, rsp_error_d;

    // Request fields captured at accept, used when the read happens after wait states.
    logic               cap_write_q, cap_write_d;
    logic [1:0]         cap_size_q, cap_size_d;
    logic               cap_signed_q, cap_signed_d;
    logic [1:0]         cap_lane_q, cap_lane_d;
    logic               cap_err_q, cap_err_d;
    logic [IDX_W-1:0]   cap_idx_q, cap_idx_d;

    logic [DATA_W-1:0]  ram_q [DEPTH];

    // Live request decode
    logic               live_in_range;
    logic               live_misalign;
    logic               live_err;
    logic [1:0]         live_lane;
    logic [IDX_W-1:0]   live_idx;
    logic [NB-1:0]      live_be;
    logic [DATA_W-1:0]  live_wdata;
    logic               accept;

    // Read-side selection
    logic               sel_write;
    logic [1:0]         sel_size;
    logic               sel_signed;
    logic [1:0]         sel_lane;
    logic               sel_err;
    logic [IDX_W-1:0]   sel_idx;
    logic [DATA_W-1:0]  rd_word;
    logic [7:0]         byte_val;
    logic [15:0]        half_val;
    logic [DATA_W-1:0]  load_val;

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign read_data = read_data_q;
    assign rsp_error = rsp_error_q;

    // A request coinciding with reset must not be taken.
    assign accept = req_valid && req_ready && !reset;

    always_comb begin
        live_in_range = ({2'b00, adress[31:2]} < DEPTH_W32);
        live_idx      = live_in_range ? adress[IDX_W+1:2] : '0;

`ifdef SM_DMEM_MISALIGN_FAULT_EN
        live_misalign = ((req_size == 2'b01) && adress[0]) ||
                        ((req_size == 2'b10) && (adress[1:0] != 2'b00));
`else
        live_misalign = 1'b0;
`endif

        live_err = !live_in_range || (req_size == 2'b11) || live_misalign;

        // Low address bits the access size cannot use are dropped.
        live_lane = 2'b00;
        live_be   = '0;
        case (req_size)
            2'b00: begin
                live_lane = adress[1:0];
                live_be   = {{(NB-1){1'b0}}, 1'b1} << live_lane;
            end
            2'b01: begin
                live_lane = {adress[1], 1'b0};
                live_be   = {{(NB-2){1'b0}}, 2'b11} << live_lane;
            end
            2'b10: begin
                live_lane = 2'b00;
                live_be   = '1;
            end
            default: begin
                live_lane = 2'b00;
                live_be   = '0;
            end
        endcase

        // Right-aligned store data moved up to its lane.
        live_wdata = write_data << {live_lane, 3'b000};
    end

    // Stores commit at the accept edge so any later load sees them.
    always_ff @(posedge clk) begin
        if (accept && req_write && !live_err) begin
            for (int b = 0; b < NB; b++) begin
                if (live_be[b]) begin
                    ram_q[live_idx][b*8 +: 8] <= live_wdata[b*8 +: 8];
                end
            end
        end
    end

    // With zero wait states the read happens on the accept edge itself,
    // so the live request is used; otherwise the captured copy.
    always_comb begin
        if (state_q == ST_IDLE) begin
            sel_write  = req_write;
            sel_size   = req_size;
            sel_signed = req_signed;
            sel_lane   = live_lane;
            sel_err    = live_err;
            sel_idx    = live_idx;
        end else begin
            sel_write  = cap_write_q;
            sel_size   = cap_size_q;
            sel_signed = cap_signed_q;
            sel_lane   = cap_lane_q;
            sel_err    = cap_err_q;
            sel_idx    = cap_idx_q;
        end
    end

    always_comb begin
        rd_word  = ram_q[sel_idx];
        byte_val = rd_word[{sel_lane, 3'b000} +: 8];
        half_val = rd_word[{sel_lane[1], 4'b0000} +: 16];
        case (sel_size)
            2'b00:   load_val = {{(DATA_W-8){sel_signed & byte_val[7]}}, byte_val};
            2'b01:   load_val = {{(DATA_W-16){sel_signed & half_val[15]}}, half_val};
            2'b10:   load_val = rd_word;
            default: load_val = '0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        read_data_d  = read_data_q;
        rsp_error_d  = rsp_error_q;
        cap_write_d  = cap_write_q;
        cap_size_d   = cap_size_q;
        cap_signed_d = cap_signed_q;
        cap_lane_d   = cap_lane_q;
        cap_err_d    = cap_err_q;
        cap_idx_d    = cap_idx_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    cap_write_d  = req_write;
                    cap_size_d   = req_size;
                    cap_signed_d = req_signed;
                    cap_lane_d   = live_lane;
                    cap_err_d    = live_err;
                    cap_idx_d    = live_idx;
                    if (WAIT_STATES > 0) begin
                        state_d    = ST_WAIT;
                        wait_cnt_d = WAIT_LOAD;
                    end else begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_WAIT: begin
                if (wait_cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Result is registered on the edge entering RESP and held through it.
        if ((state_d == ST_RESP) && (state_q != ST_RESP)) begin
            read_data_d = (sel_err || sel_write) ? '0 : load_val;
            rsp_error_d = sel_err;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            wait_cnt_q   <= 4'd0;
            read_data_q  <= '0;
            rsp_error_q  <= 1'b0;
            cap_write_q  <= 1'b0;
            cap_size_q   <= 2'b00;
            cap_signed_q <= 1'b0;
            cap_lane_q   <= 2'b00;
            cap_err_q    <= 1'b0;
            cap_idx_q    <= '0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            read_data_q  <= read_data_d;
            rsp_error_q  <= rsp_error_d;
            cap_write_q  <= cap_write_d;
            cap_size_q   <= cap_size_d;
            cap_signed_q <= cap_signed_d;
            cap_lane_q   <= cap_lane_d;
            cap_err_q    <= cap_err_d;
            cap_idx_q    <= cap_idx_d;
        end
    end

endmodule

// File: tb/tb_sm_data_memory_ctrl.sv
// Bench for sm_data_memory_ctrl: one instance with no wait states, one with three.
// Directed transactions with hand-computed expected data, latency and handshake timing.
// Request fields are scrambled right after each accept to confirm they were captured.

module tb_sm_data_memory_ctrl;

    logic        clk;
    logic        reset;
    logic        req_valid0, req_valid3;
    logic        req_ready0, req_ready3;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] adress;
    logic [31:0] write_data;
    logic        rsp_valid0, rsp_valid3;
    logic [31:0] read_data0, read_data3;
    logic        rsp_error0, rsp_error3;

    int total;
    int bad;

    sm_data_memory_ctrl #(.DATA_W(32), .DEPTH(64), .WAIT_STATES(0)) u_dut_ws0 (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid0),
        .req_ready  (req_ready0),
        .req_write  (req_write),
        .req_size   (req_size),
        .req_signed (req_signed),
        .adress     (adress),
        .write_data (write_data),
        .rsp_valid  (rsp_valid0),
        .read_data  (read_data0),
        .rsp_error  (rsp_error0)
    );

    sm_data_memory_ctrl #(.DATA_W(32), .DEPTH(64), .WAIT_STATES(3)) u_dut_ws3 (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid3),
        .req_ready  (req_ready3),
        .req_write  (req_write),
        .req_size   (req_size),
        .req_signed (req_signed),
        .adress     (adress),
        .write_data (write_data),
        .rsp_valid  (rsp_valid3),
        .read_data  (read_data3),
        .rsp_error  (rsp_error3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One full transaction on the selected instance; checks handshake timing too.
    task automatic txn(input bit ws3, input logic wr, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output logic er);
        int lat;
        int lowcnt;
        bit got;
        @(negedge clk);
        req_write  = wr;
        req_size   = sz;
        req_signed = sg;
        adress     = a;
        write_data = wd;
        if (ws3) req_valid3 = 1'b1;
        else     req_valid0 = 1'b1;
        check_val("ready_before", ws3 ? req_ready3 : req_ready0, 1);
        @(posedge clk);
        #1;
        req_valid0 = 1'b0;
        req_valid3 = 1'b0;
        req_write  = ~wr;
        req_size   = 2'b11;
        req_signed = ~sg;
        adress     = 32'hFFFF_FFFC;
        write_data = 32'h0;
        lat    = 1;
        lowcnt = 0;
        got    = 1'b0;
        rd     = '0;
        er     = 1'b0;
        while (!got && lat <= 20) begin
            if (!(ws3 ? req_ready3 : req_ready0)) lowcnt++;
            if (ws3 ? rsp_valid3 : rsp_valid0) begin
                got = 1'b1;
                rd  = ws3 ? read_data3 : read_data0;
                er  = ws3 ? rsp_error3 : rsp_error0;
            end else begin
                @(posedge clk);
                #1;
                lat++;
            end
        end
        check_val("rsp_seen", 32'(got), 1);
        check_val("latency", lat, ws3 ? 4 : 1);
        check_val("ready_low_cycles", lowcnt, ws3 ? 4 : 1);
        @(posedge clk);
        #1;
        check_val("pulse_single", ws3 ? rsp_valid3 : rsp_valid0, 0);
        check_val("ready_after", ws3 ? req_ready3 : req_ready0, 1);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          seen;

        total      = 0;
        bad        = 0;
        reset      = 1'b1;
        req_valid0 = 1'b1;   // presented during reset: must not be accepted
        req_valid3 = 1'b0;
        req_write  = 1'b0;
        req_size   = 2'b10;
        req_signed = 1'b0;
        adress     = 32'h0;
        write_data = 32'h0;

        repeat (2) @(posedge clk);
        #1;
        check_val("rst_ready0", req_ready0, 1);
        check_val("rst_valid0", rsp_valid0, 0);
        check_val("rst_rdata0", read_data0, 0);
        check_val("rst_error0", rsp_error0, 0);
        check_val("rst_ready3", req_ready3, 1);
        check_val("rst_valid3", rsp_valid3, 0);
        check_val("rst_rdata3", read_data3, 0);
        @(negedge clk);
        reset      = 1'b0;
        req_valid0 = 1'b0;

        // Basic store / load, no wait states
        txn(0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, rd, er);
        check_val("st10_err", er, 0);
        check_val("st10_rdata", rd, 0);
        txn(0, 0, 2'b10, 0, 32'h10, 32'h0, rd, er);
        check_val("ld10", rd, 32'hDEADBEEF);

        // Lanes
        txn(0, 1, 2'b10, 0, 32'h20, 32'h11223344, rd, er);
        txn(0, 1, 2'b00, 0, 32'h21, 32'h123456AA, rd, er);
        check_val("stb21_err", er, 0);
        txn(0, 0, 2'b10, 0, 32'h20, 32'h0, rd, er);
        check_val("ldw20", rd, 32'h1122AA44);
        txn(0, 0, 2'b00, 1, 32'h21, 32'h0, rd, er);
        check_val("ldb21_s", rd, 32'hFFFFFFAA);
        txn(0, 0, 2'b00, 0, 32'h21, 32'h0, rd, er);
        check_val("ldb21_u", rd, 32'h000000AA);
        txn(0, 0, 2'b01, 1, 32'h22, 32'h0, rd, er);
        check_val("ldh22_s", rd, 32'h00001122);
        txn(0, 0, 2'b01, 1, 32'h20, 32'h0, rd, er);
        check_val("ldh20_s", rd, 32'hFFFFAA44);
        txn(0, 0, 2'b01, 0, 32'h20, 32'h0, rd, er);
        check_val("ldh20_u", rd, 32'h0000AA44);
        txn(0, 0, 2'b00, 1, 32'h23, 32'h0, rd, er);
        check_val("ldb23_s", rd, 32'h00000011);

        // Last word in range
        txn(0, 1, 2'b10, 0, 32'hFC, 32'h0F0E0D0C, rd, er);
        check_val("stFC_err", er, 0);
        txn(0, 0, 2'b10, 0, 32'hFC, 32'h0, rd, er);
        check_val("ldFC", rd, 32'h0F0E0D0C);

        // Errors
        txn(0, 1, 2'b10, 0, 32'h0, 32'hCAFEF00D, rd, er);
        txn(0, 0, 2'b10, 0, 32'h100, 32'h0, rd, er);
        check_val("ld100_err", er, 1);
        check_val("ld100_rdata", rd, 0);
        txn(0, 1, 2'b10, 0, 32'h100, 32'h99999999, rd, er);
        check_val("st100_err", er, 1);
        txn(0, 1, 2'b11, 0, 32'h0, 32'h12345678, rd, er);
        check_val("st_sz3_err", er, 1);
        txn(0, 0, 2'b11, 0, 32'h0, 32'h0, rd, er);
        check_val("ld_sz3_err", er, 1);
        check_val("ld_sz3_rdata", rd, 0);
        txn(0, 0, 2'b10, 0, 32'h0, 32'h0, rd, er);
        check_val("ld0_kept", rd, 32'hCAFEF00D);
        check_val("ld0_err", er, 0);

        // Misalignment
        txn(0, 1, 2'b10, 0, 32'h30, 32'h0, rd, er);
        txn(0, 1, 2'b01, 0, 32'h31, 32'h0000BEEF, rd, er);
`ifdef SM_DMEM_MISALIGN_FAULT_EN
        check_val("sth31_err", er, 1);
        txn(0, 0, 2'b10, 0, 32'h30, 32'h0, rd, er);
        check_val("ldw30", rd, 32'h00000000);
        txn(0, 0, 2'b10, 0, 32'h33, 32'h0, rd, er);
        check_val("ldw33_err", er, 1);
        check_val("ldw33_rdata", rd, 0);
`else
        check_val("sth31_err", er, 0);
        txn(0, 0, 2'b10, 0, 32'h30, 32'h0, rd, er);
        check_val("ldw30", rd, 32'h0000BEEF);
        txn(0, 0, 2'b10, 0, 32'h33, 32'h0, rd, er);
        check_val("ldw33_err", er, 0);
        check_val("ldw33_rdata", rd, 32'h0000BEEF);
`endif

        // Wait states: back-to-back store then load
        txn(1, 1, 2'b10, 0, 32'h40, 32'h0BADF00D, rd, er);
        check_val("ws3_st_err", er, 0);
        txn(1, 0, 2'b10, 0, 32'h40, 32'h0, rd, er);
        check_val("ws3_ld", rd, 32'h0BADF00D);
        txn(1, 0, 2'b00, 1, 32'h43, 32'h0, rd, er);
        check_val("ws3_ldb43_s", rd, 32'h0000000B);
        txn(1, 0, 2'b10, 0, 32'h100, 32'h0, rd, er);
        check_val("ws3_ld100_err", er, 1);

        // Reset while in WAIT
        @(negedge clk);
        req_write  = 1'b1;
        req_size   = 2'b10;
        req_signed = 1'b0;
        adress     = 32'h8;
        write_data = 32'h5;
        req_valid3 = 1'b1;
        @(posedge clk);
        #1;
        req_valid3 = 1'b0;
        check_val("midrst_in_wait", req_ready3, 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_val("midrst_ready", req_ready3, 1);
        check_val("midrst_rdata", read_data3, 0);
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (rsp_valid3) seen++;
        end
        check_val("midrst_no_rsp", seen, 0);
        txn(1, 0, 2'b10, 0, 32'h8, 32'h0, rd, er);
        check_val("midrst_ld8", rd, 32'h5);
        check_val("midrst_ld8_err", er, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
